// File: rtl/lenet_frame_ctrl.sv
// lenet_frame_ctrl: frame sequencer around the lenet pipeline.
// Throttles host input, drives net_valid/act/flush, collects results.
// Ports: clk, rst (async high); start/busy/done frame control;
//   s_valid/s_data/s_ready host stream; net_valid/net_act/net_flush
//   to lenet; net_ready/net_out from lenet; m_valid/m_data/m_last
//   result stream; out_count, overrun, err_timeout status.
// Optional macro LENET_FRAME_CTRL_TIMEOUT_EN adds a DRAIN timeout.
module lenet_frame_ctrl #(
  parameter int IN_W         = 400,
  parameter int OUT_W        = 256,
  parameter int IN_BEATS     = 1024,
  parameter int OUT_BEATS    = 25,
  parameter int FLUSH_CYCLES = 64,
  parameter int TO_CYCLES    = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  input  logic                           s_valid,
  input  logic [IN_W-1:0]                s_data,
  output logic                           s_ready,
  output logic                           net_valid,
  output logic [IN_W-1:0]                net_act,
  output logic                           net_flush,
  input  logic                           net_ready,
  input  logic [OUT_W-1:0]               net_out,
  output logic                           m_valid,
  output logic [OUT_W-1:0]               m_data,
  output logic                           m_last,
  output logic [$clog2(OUT_BEATS+1)-1:0] out_count,
  output logic                           overrun,
  output logic                           err_timeout
);

  localparam int ICW = $clog2(IN_BEATS + 1);
  localparam int OCW = $clog2(OUT_BEATS + 1);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [ICW-1:0] IN_LAST  = ICW'(IN_BEATS - 1);
  localparam logic [OCW-1:0] OUT_FULL = OCW'(OUT_BEATS);
  localparam logic [OCW-1:0] OUT_LAST = OCW'(OUT_BEATS - 1);
  localparam logic [FCW-1:0] FL_LAST  = FCW'(FLUSH_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STREAM = 3'd1;
  localparam logic [2:0] S_FLUSH  = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [ICW-1:0]   in_cnt_q, in_cnt_d;
  logic [OCW-1:0]   out_cnt_q, out_cnt_d;
  logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
  logic             net_valid_q, net_valid_d;
  logic [IN_W-1:0]  net_act_q, net_act_d;
  logic             m_valid_q, m_valid_d;
  logic [OUT_W-1:0] m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             overrun_q, overrun_d;
  logic             in_frame;
  logic             to_hit;

  assign in_frame = (state_q == S_STREAM) ||
                    (state_q == S_FLUSH)  ||
                    (state_q == S_DRAIN);

`ifdef LENET_FRAME_CTRL_TIMEOUT_EN
  localparam int TCW = $clog2(TO_CYCLES + 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(TO_CYCLES - 1);

  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           err_timeout_q, err_timeout_d;

  // Counter is zero outside DRAIN, so it starts from 0 on entry.
  always_comb begin
    to_cnt_d      = '0;
    err_timeout_d = err_timeout_q;
    to_hit        = 1'b0;
    if (state_q == S_IDLE && start) begin
      err_timeout_d = 1'b0;
    end
    if (state_q == S_DRAIN) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q == TO_LAST && out_cnt_q < OUT_FULL) begin
        to_hit        = 1'b1;
        err_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign to_hit      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    flush_cnt_d = flush_cnt_q;
    net_valid_d = 1'b0;
    net_act_d   = net_act_q;
    m_valid_d   = 1'b0;
    m_data_d    = m_data_q;
    m_last_d    = 1'b0;
    overrun_d   = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_STREAM;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          overrun_d = 1'b0;
        end
      end
      S_STREAM: begin
        // s_ready is high throughout STREAM, so s_valid is the handshake.
        if (s_valid) begin
          net_valid_d = 1'b1;
          net_act_d   = s_data;
          in_cnt_d    = in_cnt_q + 1'b1;
          if (in_cnt_q == IN_LAST) begin
            state_d     = S_FLUSH;
            flush_cnt_d = '0;
          end
        end
      end
      S_FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FL_LAST) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_cnt_q == OUT_FULL || to_hit) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result capture; beats outside a frame are silently dropped.
    if (in_frame && net_ready) begin
      if (out_cnt_q < OUT_FULL) begin
        m_valid_d = 1'b1;
        m_data_d  = net_out;
        m_last_d  = (out_cnt_q == OUT_LAST);
        out_cnt_d = out_cnt_q + 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      flush_cnt_q <= '0;
      net_valid_q <= 1'b0;
      net_act_q   <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      net_valid_q <= net_valid_d;
      net_act_q   <= net_act_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = in_frame;
  assign done      = (state_q == S_DONE);
  assign s_ready   = (state_q == S_STREAM);
  assign net_flush = (state_q == S_FLUSH);
  assign net_valid = net_valid_q;
  assign net_act   = net_act_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_last    = m_last_q;
  assign out_count = out_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_lenet_frame_ctrl.sv
// tb_lenet_frame_ctrl: directed frames with random data and
// a queue-based frame model for lenet_frame_ctrl.
module tb_lenet_frame_ctrl;

  localparam int IN_W         = 16;
  localparam int OUT_W        = 16;
  localparam int IN_BEATS     = 8;
  localparam int OUT_BEATS    = 2;
  localparam int FLUSH_CYCLES = 4;
  localparam int TO_CYCLES    = 16;
  localparam int CW           = $clog2(OUT_BEATS + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             s_valid = 1'b0;
  logic [IN_W-1:0]  s_data = '0;
  logic             net_ready = 1'b0;
  logic [OUT_W-1:0] net_out = '0;
  logic             busy, done, s_ready;
  logic             net_valid, net_flush;
  logic [IN_W-1:0]  net_act;
  logic             m_valid, m_last;
  logic [OUT_W-1:0] m_data;
  logic [CW-1:0]    out_count;
  logic             overrun, err_timeout;

  lenet_frame_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W),
    .IN_BEATS(IN_BEATS), .OUT_BEATS(OUT_BEATS),
    .FLUSH_CYCLES(FLUSH_CYCLES), .TO_CYCLES(TO_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .net_valid(net_valid), .net_act(net_act),
    .net_flush(net_flush),
    .net_ready(net_ready), .net_out(net_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .out_count(out_count), .overrun(overrun),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [IN_W-1:0]  exp_in[$];
  logic [IN_W-1:0]  net_log[$];
  logic [OUT_W-1:0] ret_q[$];
  logic [OUT_W-1:0] m_log[$];
  int hs_ticks[$];
  int nv_ticks[$];
  int last_idx[$];
  int flush_n, flush_first, done_n, done_tick, last_hs;
  logic busy_at_done;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (net_valid) begin
      nv_ticks.push_back(cyc);
      net_log.push_back(net_act);
    end
    if (m_valid) m_log.push_back(m_data);
    if (m_last) last_idx.push_back(m_valid ? m_log.size() : -1);
    if (net_flush) begin
      if (flush_n == 0) flush_first = cyc;
      flush_n++;
    end
    if (done) begin
      done_n++;
      done_tick = cyc;
      busy_at_done = busy;
    end
  endtask

  task automatic new_frame();
    exp_in.delete(); net_log.delete();
    ret_q.delete(); m_log.delete();
    hs_ticks.delete(); nv_ticks.delete(); last_idx.delete();
    flush_n = 0; flush_first = -1;
    done_n = 0; done_tick = -1; busy_at_done = 1'bx;
    last_hs = -1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input bit gapped, input bit early,
                      input bit start_mid);
    int acc;
    bit sv;
    acc = 0;
    for (int k = 0; k < 4 * IN_BEATS && acc < IN_BEATS; k++) begin
      s_valid = gapped ? (k % 2 == 0) : 1'b1;
      s_data = IN_W'($urandom);
      sv = s_valid && s_ready;
      start = start_mid && sv && acc == 3;
      net_ready = early && sv && acc == IN_BEATS - 1;
      if (net_ready) begin
        net_out = OUT_W'($urandom);
        ret_q.push_back(net_out);
      end
      tick();
      if (sv) begin
        exp_in.push_back(s_data);
        hs_ticks.push_back(cyc);
        acc++;
        last_hs = cyc;
      end
    end
    s_valid = 1'b0;
    start = 1'b0;
    net_ready = 1'b0;
  endtask

  task automatic drain(input int n_ret, input bit start_in_done,
                       input int budget);
    for (int k = 0; k < budget && done_n == 0; k++) begin
      net_ready = ret_q.size() < n_ret;
      if (net_ready) begin
        net_out = OUT_W'($urandom);
        ret_q.push_back(net_out);
      end
      tick();
    end
    net_ready = 1'b0;
    if (start_in_done && done_n > 0) begin
      start = 1'b1;
      tick();
      start = 1'b0;
      check("start_in_done_busy", busy, 0);
    end
    tick();
    tick();
  endtask

  task automatic check_frame(string p, input int n_ret,
                             input bit to_exp);
    int nexp;
    bit ok;
    nexp = n_ret < OUT_BEATS ? n_ret : OUT_BEATS;
    ok = nv_ticks.size() == hs_ticks.size();
    for (int i = 0; ok && i < hs_ticks.size(); i++)
      if (nv_ticks[i] != hs_ticks[i]) ok = 0;
    check({p, "_net_valid_timing"}, ok, 1);
    ok = net_log.size() == exp_in.size();
    for (int i = 0; ok && i < exp_in.size(); i++)
      if (net_log[i] !== exp_in[i]) ok = 0;
    check({p, "_net_act_data"}, ok, 1);
    check({p, "_flush_len"}, flush_n, FLUSH_CYCLES);
    check({p, "_flush_start"}, flush_first, last_hs);
    check({p, "_m_count"}, m_log.size(), nexp);
    ok = m_log.size() == nexp;
    for (int i = 0; ok && i < nexp; i++)
      if (m_log[i] !== ret_q[i]) ok = 0;
    check({p, "_m_data"}, ok, 1);
    if (nexp == OUT_BEATS) begin
      ok = last_idx.size() == 1 && last_idx[0] == OUT_BEATS;
      check({p, "_m_last"}, ok, 1);
    end else begin
      check({p, "_m_last_none"}, last_idx.size(), 0);
    end
    check({p, "_out_count"}, out_count, nexp);
    check({p, "_overrun"}, overrun, n_ret > OUT_BEATS);
    check({p, "_done_count"}, done_n, 1);
    check({p, "_done_tick"}, done_tick, to_exp ?
          last_hs + FLUSH_CYCLES + TO_CYCLES :
          last_hs + FLUSH_CYCLES + 1);
    check({p, "_busy_at_done"}, busy_at_done, 0);
    check({p, "_err_timeout"}, err_timeout, to_exp);
    check({p, "_idle_after"}, busy, 0);
  endtask

  task automatic check_zero(string p);
    check({p, "_busy"}, busy, 0);
    check({p, "_done"}, done, 0);
    check({p, "_s_ready"}, s_ready, 0);
    check({p, "_net_valid"}, net_valid, 0);
    check({p, "_net_act"}, net_act, 0);
    check({p, "_net_flush"}, net_flush, 0);
    check({p, "_m_valid"}, m_valid, 0);
    check({p, "_m_data"}, m_data, 0);
    check({p, "_m_last"}, m_last, 0);
    check({p, "_out_count"}, out_count, 0);
    check({p, "_overrun"}, overrun, 0);
    check({p, "_err_timeout"}, err_timeout, 0);
  endtask

  initial begin
    new_frame();
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    check_zero("idle");

    // Nominal frame.
    new_frame();
    start_frame();
    check("t1_busy_after_start", busy, 1);
    check("t1_s_ready", s_ready, 1);
    feed(0, 0, 0);
    drain(2, 0, 40);
    check_frame("t1", 2, 0);

    // Gapped input with a result beat on the last input beat.
    new_frame();
    start_frame();
    feed(1, 1, 0);
    drain(2, 0, 40);
    check_frame("t2", 2, 0);

    // Overrun.
    new_frame();
    start_frame();
    feed(0, 0, 0);
    drain(3, 0, 40);
    check_frame("t3", 3, 0);

    // Start ignored mid-STREAM and in DONE.
    new_frame();
    start_frame();
    feed(1, 0, 1);
    drain(2, 1, 40);
    check_frame("t4", 2, 0);

    // Reset in FLUSH, then a clean frame.
    new_frame();
    start_frame();
    feed(0, 0, 0);
    tick();
    tick();
    check("t5_in_flush", net_flush, 1);
    #2 rst = 1'b1;
    #1;
    check_zero("t5_async");
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t5_no_done", done_n, 0);
    new_frame();
    start_frame();
    feed(0, 1, 0);
    drain(2, 0, 40);
    check_frame("t5_clean", 2, 0);

    // Only one of two results returns.
    new_frame();
    start_frame();
    feed(0, 0, 0);
`ifdef LENET_FRAME_CTRL_TIMEOUT_EN
    drain(1, 0, FLUSH_CYCLES + TO_CYCLES + 20);
    check_frame("t6", 1, 1);
`else
    drain(1, 0, FLUSH_CYCLES + TO_CYCLES + 20);
    check("t6_no_done", done_n, 0);
    check("t6_busy", busy, 1);
    check("t6_err_timeout", err_timeout, 0);
    check("t6_out_count", out_count, 1);
    #2 rst = 1'b1;
    #1;
    check_zero("t6_reset");
    tick();
    rst = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
